// File: rtl/rv32i_pkg.sv
// Operation-type encodings shared by decode, execute and the memory stage.
package rv32i_pkg;

    localparam int OPC_W = 11;

    localparam logic [OPC_W-1:0] LH    = 11'd0;
    localparam logic [OPC_W-1:0] LB    = 11'd1;
    localparam logic [OPC_W-1:0] LW    = 11'd2;
    localparam logic [OPC_W-1:0] LHU   = 11'd3;
    localparam logic [OPC_W-1:0] LBU   = 11'd4;
    localparam logic [OPC_W-1:0] SB    = 11'd5;
    localparam logic [OPC_W-1:0] SH    = 11'd6;
    localparam logic [OPC_W-1:0] SW    = 11'd7;
    localparam logic [OPC_W-1:0] ADD   = 11'd8;
    localparam logic [OPC_W-1:0] SUB   = 11'd9;
    localparam logic [OPC_W-1:0] SLL   = 11'd10;
    localparam logic [OPC_W-1:0] SLT   = 11'd11;
    localparam logic [OPC_W-1:0] SLTU  = 11'd12;
    localparam logic [OPC_W-1:0] XOR   = 11'd13;
    localparam logic [OPC_W-1:0] SRL   = 11'd14;
    localparam logic [OPC_W-1:0] SRA   = 11'd15;
    localparam logic [OPC_W-1:0] OR    = 11'd16;
    localparam logic [OPC_W-1:0] AND   = 11'd17;
    localparam logic [OPC_W-1:0] ADDI  = 11'd18;
    localparam logic [OPC_W-1:0] SLTI  = 11'd19;
    localparam logic [OPC_W-1:0] SLTIU = 11'd20;
    localparam logic [OPC_W-1:0] XORI  = 11'd21;
    localparam logic [OPC_W-1:0] ORI   = 11'd22;
    localparam logic [OPC_W-1:0] ANDI  = 11'd23;
    localparam logic [OPC_W-1:0] SLLI  = 11'd24;
    localparam logic [OPC_W-1:0] SRLI  = 11'd25;
    localparam logic [OPC_W-1:0] SRAI  = 11'd26;
    localparam logic [OPC_W-1:0] LUI   = 11'd27;
    localparam logic [OPC_W-1:0] AUIPC = 11'd28;
    localparam logic [OPC_W-1:0] BEQ   = 11'd29;
    localparam logic [OPC_W-1:0] BNE   = 11'd30;
    localparam logic [OPC_W-1:0] BLT   = 11'd31;
    localparam logic [OPC_W-1:0] BGE   = 11'd32;
    localparam logic [OPC_W-1:0] BLTU  = 11'd33;
    localparam logic [OPC_W-1:0] BGEU  = 11'd34;
    localparam logic [OPC_W-1:0] JAL   = 11'd35;
    localparam logic [OPC_W-1:0] JALR  = 11'd36;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    // Loads occupy the bottom of the encoding space, so one upper bound suffices.
    function automatic logic is_load(input logic [OPC_W-1:0] opc);
        return opc <= LBU;
    endfunction

    function automatic logic is_store(input logic [OPC_W-1:0] opc);
        return (opc >= SB) && (opc <= SW);
    endfunction

    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return (opc >= BEQ) && (opc <= BGEU);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: byte enables, store-data replication,
// load extraction/extension and misalignment detection.
import rv32i_pkg::*;

module mem_align (
    input  logic [OPC_W-1:0] i_opc,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    input  logic [31:0]      i_rdata,
    output logic [3:0]       o_be,
    output logic [31:0]      o_wdata,
    output logic [31:0]      o_ld_data,
    output logic             o_misalign
);

    logic [31:0] w_shift;

    assign w_shift = i_rdata >> {i_addr[1:0], 3'b000};

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        case (i_opc)
            SB: begin
                o_be    = 4'b0001 << i_addr[1:0];
                o_wdata = {4{i_wdata[7:0]}};
            end
            SH: begin
                o_be       = 4'b0011 << i_addr[1:0];
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr[0];
            end
            SW, LW:  o_misalign = |i_addr[1:0];
            LH, LHU: o_misalign = i_addr[0];
            default: ;
        endcase
    end

    always_comb begin
        o_ld_data = w_shift;
        case (i_opc)
            LB:      o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            LBU:     o_ld_data = {24'd0, w_shift[7:0]};
            LH:      o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            LHU:     o_ld_data = {16'd0, w_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to writeback, runs one data-memory
// access at a time (REQ until grant, WAIT until read data), stalling execute meanwhile.
import rv32i_pkg::*;

module mem_stage #(
    parameter int OPC_W = rv32i_pkg::OPC_W
) (
    input  logic             clk,
    input  logic             rstl,
    input  logic             valid_exe_2_mem_i,
    input  logic [OPC_W-1:0] opcode_exe_2_mem_i,
    input  logic [4:0]       rd_exe_2_mem_i,
    input  logic [31:0]      rd_data_exe_2_mem_i,
    input  logic [31:0]      mem_address_i,
    input  logic [31:0]      men_data_i,
    output logic             ready_mem_2_exe_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic [3:0]       dmem_be_o,
    output logic [31:0]      dmem_addr_o,
    output logic [31:0]      dmem_wdata_o,
    input  logic             dmem_gnt_i,
    input  logic             dmem_rvalid_i,
    input  logic [31:0]      dmem_rdata_i,
    output logic             valid_mem_2_wb_o,
    output logic             we_mem_2_wb_o,
    output logic [4:0]       rd_mem_2_wb_o,
    output logic [31:0]      rd_data_mem_2_wb_o,
    output logic             misalign_o
);

    mem_state_t       r_state;
    mem_state_t       w_next_state;
    logic [OPC_W-1:0] r_opc;
    logic [4:0]       r_rd;
    logic [31:0]      r_addr;
    logic             r_dmem_req, r_dmem_we;
    logic [3:0]       r_dmem_be;
    logic [31:0]      r_dmem_addr, r_dmem_wdata;
    logic             r_wb_vld, r_wb_we, r_misalign;
    logic [4:0]       r_wb_rd;
    logic [31:0]      r_wb_data;

    logic             w_idle, w_accept, w_is_mem, w_start, w_misalign;
    logic [OPC_W-1:0] w_al_opc;
    logic [31:0]      w_al_addr, w_wdata, w_ld_data;
    logic [3:0]       w_be;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = valid_exe_2_mem_i && w_idle;
    assign w_is_mem = is_load(opcode_exe_2_mem_i) || is_store(opcode_exe_2_mem_i);
    assign w_start  = w_accept && w_is_mem && !w_misalign;

    // In IDLE the aligner works on the incoming op; afterwards on the captured one.
    assign w_al_opc  = w_idle ? opcode_exe_2_mem_i : r_opc;
    assign w_al_addr = w_idle ? mem_address_i : r_addr;

    mem_align u_align (
        .i_opc      (w_al_opc),
        .i_addr     (w_al_addr),
        .i_wdata    (men_data_i),
        .i_rdata    (dmem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk or posedge rstl) begin
        if (rstl) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start)       w_next_state = ST_REQ;
            ST_REQ:  if (dmem_gnt_i)    w_next_state = is_store(r_opc) ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (dmem_rvalid_i) w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstl) begin
        if (rstl) begin
            r_opc        <= '0;
            r_rd         <= '0;
            r_addr       <= '0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= '0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_wb_vld     <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_wb_vld   <= 1'b0;
            r_wb_we    <= 1'b0;
            r_misalign <= 1'b0;
            if (w_accept) begin
                r_opc  <= opcode_exe_2_mem_i;
                r_rd   <= rd_exe_2_mem_i;
                r_addr <= mem_address_i;
                if (!w_is_mem) begin
                    r_wb_vld  <= 1'b1;
                    r_wb_we   <= (rd_exe_2_mem_i != 5'd0) && !is_branch(opcode_exe_2_mem_i);
                    r_wb_rd   <= rd_exe_2_mem_i;
                    r_wb_data <= rd_data_exe_2_mem_i;
                end else if (w_misalign) begin
                    r_wb_vld   <= 1'b1;
                    r_misalign <= 1'b1;
                    r_wb_rd    <= rd_exe_2_mem_i;
                    r_wb_data  <= '0;
                end else begin
                    r_dmem_req   <= 1'b1;
                    r_dmem_we    <= is_store(opcode_exe_2_mem_i);
                    r_dmem_be    <= w_be;
                    r_dmem_addr  <= {mem_address_i[31:2], 2'b00};
                    r_dmem_wdata <= w_wdata;
                end
            end
            if ((r_state == ST_REQ) && dmem_gnt_i) begin
                r_dmem_req <= 1'b0;
                r_dmem_we  <= 1'b0;
                if (is_store(r_opc)) begin
                    r_wb_vld  <= 1'b1;
                    r_wb_rd   <= r_rd;
                    r_wb_data <= '0;
                end
            end
            if ((r_state == ST_WAIT) && dmem_rvalid_i) begin
                r_wb_vld  <= 1'b1;
                r_wb_we   <= (r_rd != 5'd0);
                r_wb_rd   <= r_rd;
                r_wb_data <= w_ld_data;
            end
        end
    end

    assign ready_mem_2_exe_o  = w_idle;
    assign dmem_req_o         = r_dmem_req;
    assign dmem_we_o          = r_dmem_we;
    assign dmem_be_o          = r_dmem_be;
    assign dmem_addr_o        = r_dmem_addr;
    assign dmem_wdata_o       = r_dmem_wdata;
    assign valid_mem_2_wb_o   = r_wb_vld;
    assign we_mem_2_wb_o      = r_wb_we;
    assign rd_mem_2_wb_o      = r_wb_rd;
    assign rd_data_mem_2_wb_o = r_wb_data;
    assign misalign_o         = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; writeback pulses are matched against a scoreboard queue.
import rv32i_pkg::*;

module tb_mem_stage;

    logic             clk;
    logic             rstl;
    logic             valid_i;
    logic [OPC_W-1:0] opc_i;
    logic [4:0]       rd_i;
    logic [31:0]      rd_data_i;
    logic [31:0]      addr_i;
    logic [31:0]      data_i;
    logic             ready_o;
    logic             req_o, we_o;
    logic [3:0]       be_o;
    logic [31:0]      daddr_o, wdata_o;
    logic             gnt_i, rvalid_i;
    logic [31:0]      rdata_i;
    logic             wb_vld, wb_we, mis_o;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    mem_stage #(.OPC_W(OPC_W)) dut (
        .clk                 (clk),
        .rstl                (rstl),
        .valid_exe_2_mem_i   (valid_i),
        .opcode_exe_2_mem_i  (opc_i),
        .rd_exe_2_mem_i      (rd_i),
        .rd_data_exe_2_mem_i (rd_data_i),
        .mem_address_i       (addr_i),
        .men_data_i          (data_i),
        .ready_mem_2_exe_o   (ready_o),
        .dmem_req_o          (req_o),
        .dmem_we_o           (we_o),
        .dmem_be_o           (be_o),
        .dmem_addr_o         (daddr_o),
        .dmem_wdata_o        (wdata_o),
        .dmem_gnt_i          (gnt_i),
        .dmem_rvalid_i       (rvalid_i),
        .dmem_rdata_i        (rdata_i),
        .valid_mem_2_wb_o    (wb_vld),
        .we_mem_2_wb_o       (wb_we),
        .rd_mem_2_wb_o       (wb_rd),
        .rd_data_mem_2_wb_o  (wb_data),
        .misalign_o          (mis_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic we, input logic mis,
                        input logic chk_dat, input logic [31:0] dat);
        exp_t e;
        e.rd = rd; e.we = we; e.mis = mis; e.chk_dat = chk_dat; e.dat = dat;
        sb_q.push_back(e);
    endtask

    // Advance to the next falling edge and score any writeback pulse seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (wb_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_vld}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_misalign", {31'd0, mis_o}, {31'd0, e.mis});
                if (e.chk_dat) chk("wb_data", wb_data, e.dat);
            end
        end
    endtask

    task automatic send(input logic [OPC_W-1:0] opc, input logic [4:0] rd,
                        input logic [31:0] rdat, input logic [31:0] addr, input logic [31:0] data);
        valid_i = 1'b1; opc_i = opc; rd_i = rd; rd_data_i = rdat; addr_i = addr; data_i = data;
        tick();
        valid_i = 1'b0;
        opc_i = ADD; rd_i = 5'd31; rd_data_i = 32'hBAD0BAD0; addr_i = 32'hFFFF_FFFF; data_i = 32'h5555_5555;
    endtask

    task automatic do_store(input logic [OPC_W-1:0] opc, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata, input int gnt_wait);
        push(5'd2, 1'b0, 1'b0, 1'b0, 32'd0);
        send(opc, 5'd2, 32'd0, addr, data);
        chk("st_req", {31'd0, req_o}, 32'd1);
        chk("st_we", {31'd0, we_o}, 32'd1);
        chk("st_addr", daddr_o, addr & 32'hFFFF_FFFC);
        chk("st_be", {28'd0, be_o}, {28'd0, exp_be});
        chk("st_wdata", wdata_o, exp_wdata);
        chk("st_ready", {31'd0, ready_o}, 32'd0);
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            chk("st_req_held", {31'd0, req_o}, 32'd1);
            chk("st_wdata_held", wdata_o, exp_wdata);
        end
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        chk("st_req_done", {31'd0, req_o}, 32'd0);
        chk("st_ready_done", {31'd0, ready_o}, 32'd1);
        chk("st_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_load(input logic [OPC_W-1:0] opc, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_dat, input logic exp_we,
                           input int rv_wait);
        push(rd, exp_we, 1'b0, 1'b1, exp_dat);
        send(opc, rd, 32'd0, addr, 32'd0);
        chk("ld_req", {31'd0, req_o}, 32'd1);
        chk("ld_we", {31'd0, we_o}, 32'd0);
        chk("ld_addr", daddr_o, addr & 32'hFFFF_FFFC);
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        chk("ld_req_done", {31'd0, req_o}, 32'd0);
        chk("ld_ready_wait", {31'd0, ready_o}, 32'd0);
        for (int i = 1; i < rv_wait; i++) begin
            tick();
            chk("ld_ready_wait", {31'd0, ready_o}, 32'd0);
        end
        rdata_i = rdata; rvalid_i = 1'b1;
        tick();
        rvalid_i = 1'b0; rdata_i = 32'h0;
        chk("ld_ready_done", {31'd0, ready_o}, 32'd1);
        chk("ld_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rstl = 1'b1; valid_i = 1'b0; opc_i = ADD; rd_i = 5'd0; rd_data_i = 32'd0;
        addr_i = 32'd0; data_i = 32'd0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, req_o}, 32'd0);
        chk("rst_dwe", {31'd0, we_o}, 32'd0);
        chk("rst_be", {28'd0, be_o}, 32'd0);
        chk("rst_addr", daddr_o, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_vld", {31'd0, wb_vld}, 32'd0);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        chk("rst_mis", {31'd0, mis_o}, 32'd0);
        rstl = 1'b0;
        tick();
        chk("rst_ready", {31'd0, ready_o}, 32'd1);

        // ALU results, zero destination and branches
        push(5'd5, 1'b1, 1'b0, 1'b1, 32'h0000_1234);
        send(ADD, 5'd5, 32'h1234, 32'd0, 32'd0);
        chk("add_ready", {31'd0, ready_o}, 32'd1);
        tick();
        chk("add_pulse", {31'd0, wb_vld}, 32'd0);
        push(5'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0077);
        send(ADD, 5'd0, 32'h77, 32'd0, 32'd0);
        push(5'd4, 1'b0, 1'b0, 1'b0, 32'd0);
        send(BEQ, 5'd4, 32'h1, 32'd0, 32'd0);
        push(5'd1, 1'b1, 1'b0, 1'b1, 32'h0000_0104);
        send(JALR, 5'd1, 32'h104, 32'd0, 32'd0);
        tick();

        // Stores
        do_store(SB, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 2);
        do_store(SH, 32'h0000_0102, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF, 0);
        do_store(SW, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);

        // Loads
        do_load(LB,  5'd7, 32'h0000_0102, 32'h0080_0000, 32'hFFFF_FF80, 1'b1, 3);
        do_load(LBU, 5'd7, 32'h0000_0102, 32'h0080_0000, 32'h0000_0080, 1'b1, 3);
        do_load(LH,  5'd8, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001, 1'b1, 1);
        do_load(LHU, 5'd8, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001, 1'b1, 2);
        do_load(LW,  5'd6, 32'h0000_0044, 32'h1234_5678, 32'h1234_5678, 1'b1, 1);
        do_load(LW,  5'd0, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1);

        // Stray read response while idle must be ignored
        rvalid_i = 1'b1; rdata_i = 32'h1111_1111;
        tick();
        rvalid_i = 1'b0;
        chk("stray_idle_ready", {31'd0, ready_o}, 32'd1);

        // Misaligned accesses
        push(5'd3, 1'b0, 1'b1, 1'b0, 32'd0);
        send(LW, 5'd3, 32'd0, 32'h0000_0202, 32'd0);
        chk("mis_no_req", {31'd0, req_o}, 32'd0);
        chk("mis_ready", {31'd0, ready_o}, 32'd1);
        tick();
        chk("mis_pulse", {31'd0, mis_o}, 32'd0);
        chk("mis_vld_pulse", {31'd0, wb_vld}, 32'd0);
        push(5'd2, 1'b0, 1'b1, 1'b0, 32'd0);
        send(SH, 5'd2, 32'd0, 32'h0000_0101, 32'h0000_FFFF);
        chk("mis_sh_no_req", {31'd0, req_o}, 32'd0);
        tick();

        // Reset while waiting for read data abandons the access
        send(LW, 5'd9, 32'd0, 32'h0000_0080, 32'd0);
        gnt_i = 1'b1;
        tick();
        gnt_i = 1'b0;
        chk("rw_in_wait", {31'd0, ready_o}, 32'd0);
        rstl = 1'b1;
        tick();
        chk("rw_req", {31'd0, req_o}, 32'd0);
        chk("rw_ready_rst", {31'd0, ready_o}, 32'd1);
        rstl = 1'b0;
        rvalid_i = 1'b1; rdata_i = 32'h2222_2222;
        tick();
        rvalid_i = 1'b0;
        tick();
        chk("rw_ready", {31'd0, ready_o}, 32'd1);
        chk("rw_no_wb", {31'd0, wb_vld}, 32'd0);

        // Normal operation resumes after the abandoned access
        push(5'd10, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001);
        send(SUB, 5'd10, 32'hA5A5_0001, 32'd0, 32'd0);
        tick();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter OPC_W, default 11, width of the operation-type code.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rstl  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valid_exe_2_mem_i  input  1  execute result present this cycle.
REQ-005 SHALL have port opcode_exe_2_mem_i  input  OPC_W  operation-type code, encodings per shared package (LH=0 … JALR=36).
REQ-006 SHALL have port rd_exe_2_mem_i  input  5  destination register number.
REQ-007 SHALL have port rd_data_exe_2_mem_i  input  32  ALU/jump result.
REQ-008 SHALL have port mem_address_i  input  32  load/store byte address.
REQ-009 SHALL have port men_data_i  input  32  store data, LSBs significant.
REQ-010 SHALL have port ready_mem_2_exe_o  output  1  stage can accept; low = stall execute.
REQ-011 SHALL have ports dmem_req_o/dmem_we_o 1, dmem_be_o 4, dmem_addr_o 32 (word-aligned), dmem_wdata_o 32, all outputs; data-memory request.
REQ-012 SHALL have ports dmem_gnt_i 1, dmem_rvalid_i 1, dmem_rdata_i 32, all inputs; grant and read response.
REQ-013 SHALL have outputs valid_mem_2_wb_o 1, we_mem_2_wb_o 1, rd_mem_2_wb_o 5, rd_data_mem_2_wb_o 32, misalign_o 1.

Function
REQ-014 SHALL use states IDLE, REQ, WAIT; IDLE→REQ on accepted valid load/store that is aligned.
REQ-015 SHALL hold dmem_req_o high in REQ with stable addr/be/we/wdata until dmem_gnt_i; store: REQ→IDLE on gnt; load: REQ→WAIT on gnt.
REQ-016 SHALL sample dmem_rvalid_i only in WAIT; WAIT→IDLE on rvalid; rvalid in any other state ignored.
REQ-017 SHALL drive ready_mem_2_exe_o = (state==IDLE); an op is accepted when valid and ready both high.
REQ-018 SHALL register non-memory ops to writeback one cycle after acceptance: valid=1, we=(rd!=0), rd_data = rd_data_exe_2_mem_i; branches (BEQ…BGEU) we=0.
REQ-019 SHALL present a store to writeback (valid=1, we=0) the cycle after gnt; a load the cycle after rvalid.
REQ-020 SHALL compute dmem_addr_o = {addr[31:2],2'b00}; SW be=1111; SH be=0011<<addr[1:0]; SB be=0001<<addr[1:0]; wdata = byte/half replicated across lanes.
REQ-021 SHALL extract load data as rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-022 SHALL flag misalignment (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0): no dmem request, misalign_o=1 and valid=1, we=0 for exactly one cycle after acceptance.
REQ-023 SHALL force we_mem_2_wb_o=0 whenever rd=0; all writeback outputs are single-cycle pulses (valid low otherwise).
REQ-024 SHALL capture opcode/rd/addr/data into internal registers at acceptance; inputs ignored while not ready.

Reset
REQ-025 SHALL on rstl high immediately set state=IDLE, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0, valid/we/misalign=0, rd=0, rd_data=0; ready_mem_2_exe_o=1 after release.
REQ-026 SHALL abandon an in-flight access on reset mid-REQ/WAIT; a later stray rvalid produces no writeback.

Structure
REQ-027 SHALL take opcode constants (LH…JALR) and OPC_W from shared package rv32i_pkg, common with execute and decode.
REQ-028 SHALL contain one sub-module mem_align (combinational: byte-enable/wdata generation, load extraction/extension, misalign detect).

Verification
REQ-029 SHALL cover ADD rd=5 data 0x1234 valid → next cycle valid=1, we=1, rd=5, data 0x00001234, ready stays 1.
REQ-030 SHALL cover SB addr 0x103 data 0xAB, gnt after 2 cycles → req held 3 cycles, addr 0x100, be 1000, wdata 0xABABABAB, wb valid we=0 cycle after gnt.
REQ-031 SHALL cover LB addr 0x102, rdata 0x00800000, rvalid 3 cycles after gnt → rd_data 0xFFFFFF80; LBU same → 0x00000080; ready low throughout.
REQ-032 SHALL cover LW addr 0x202 → no dmem_req, misalign_o=1 one cycle, we=0.
REQ-033 SHALL cover LW rd=0 addr 0x40 → access completes, valid=1, we=0.
REQ-034 SHALL cover reset asserted in WAIT, then rvalid after release → state IDLE, no writeback pulse, ready=1.
